hdlc_line_monitor: RTL and testbench
====================================

HDLC_LINE_MONITOR -- requirements
Module: hdlc_line_monitor

Interface
REQ-001 Parameter N_CH, default 1, number of independent serial lines monitored (1..8).
REQ-002 Parameter MIN_BYTES, default 1, minimum valid frame content length in bytes.
REQ-003 Parameter MAX_BYTES, default 128, maximum valid frame content length in bytes.
REQ-004 Parameter CNT_W, default 8, width of each per-channel statistics counter.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high: Clk in 1 (rising-edge clock), Rst in 1 (asynchronous reset, active high).
REQ-006 Ports SHALL be:
- Line, in, N_CH: one serial bit per channel per Clk.
- Enable, in, N_CH: per-channel monitor enable.
- ClrCnt, in, 1: synchronous clear of all statistics counters.
- Flag_Detect, out, N_CH: one-cycle pulse per flag.
- Abort_Detect, out, N_CH: one-cycle pulse per in-frame abort.
- Frame_Ok, out, N_CH: one-cycle pulse per valid frame.
- Frame_Err, out, N_CH: one-cycle pulse per malformed frame.
- Frame_Bytes, out, N_CH*LEN_W: content byte count, valid with Frame_Ok. LEN_W = clog2(MAX_BYTES+1).
- Frame_Cnt, Err_Cnt, Abort_Cnt, out, N_CH*CNT_W each: saturating counters.

Function
REQ-007 Each channel SHALL keep an 8-bit history SR (SR[0] newest) and a consecutive-ones counter ONES that saturates at 7 and clears on a 0.
REQ-008 A flag hit SHALL occur when the updated SR equals 8'h7E. Every flag hit SHALL pulse Flag_Detect.
REQ-009 All pulse outputs SHALL be registered, asserted for exactly the one cycle following the Clk edge that sampled the completing bit.
REQ-010 Each channel SHALL have a two-state FSM:
- IDLE -> ACTIVE on a flag hit.
- ACTIVE -> ACTIVE on a flag hit, with the bit counter cleared; the closing flag doubles as the next opening flag.
- ACTIVE -> IDLE when ONES reaches 7, pulsing Abort_Detect.
REQ-011 In IDLE, seven or more ones SHALL produce no pulse. This is idle fill.
REQ-012 In ACTIVE, a 0 sampled while ONES==5 SHALL be treated as a stuffed zero and not counted. Every other bit SHALL increment the bit counter BC.
REQ-013 BC SHALL saturate at (MAX_BYTES+2)*8 and SHALL never wrap.
REQ-014 On a flag hit in ACTIVE, content bits C = BC+1-8. The flag's own bits are counted; the completing bit is included.
REQ-015 Frame outcome on that flag hit:
- C==0 (back-to-back flags): no frame event.
- C%8==0 and MIN_BYTES<=C/8<=MAX_BYTES: Frame_Ok with Frame_Bytes=C/8.
- Otherwise, including a saturated BC: Frame_Err.
REQ-016 Frame_Bytes SHALL hold its last value until the next Frame_Ok.
REQ-017 Frame_Ok, Frame_Err and Abort_Detect SHALL increment Frame_Cnt, Err_Cnt and Abort_Cnt respectively. Each counter SHALL saturate at all-ones.
REQ-018 ClrCnt SHALL zero all counters on the next edge. It SHALL win over a simultaneous increment.
REQ-019 With Enable[i] low, channel i SHALL be forced to IDLE with SR=8'hFF, ONES=0 and BC=0. Its pulses SHALL be held low and its counters SHALL hold.
REQ-020 Channels SHALL be fully independent. Simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-021 Rst high SHALL immediately set every channel to IDLE, SR=8'hFF, ONES=0 and BC=0. All outputs and counters SHALL go to 0, including mid-frame. No event SHALL be generated on reset release.

Structure
REQ-022 Package hdlc_mon_pkg SHALL hold the state enum (IDLE, ACTIVE), FLAG_PATTERN=8'h7E, STUFF_ONES=5 and ABORT_ONES=7.
REQ-023 Per-channel logic SHALL be sub-module hdlc_line_monitor_ch. The top SHALL be a generate loop over N_CH plus output flattening.

Verification
REQ-024 Reset, then Line=1 for 30 cycles -> all outputs 0, no pulses.
REQ-025 Ch0: flag, 0xA5, 0xFF (LSB first, zero stuffed), flag -> Frame_Ok one cycle after the last flag bit, Frame_Bytes=2, Frame_Cnt=1, Err_Cnt=0.
REQ-026 Flag, 12 content bits, flag -> Frame_Err, Err_Cnt=1. With MAX_BYTES=4: a 5-byte frame -> Frame_Err, Err_Cnt=2.
REQ-027 Flag, 0x55, then eight 1s -> Abort_Detect one cycle after the seventh 1, Abort_Cnt=1, no Frame_Ok. The channel then ignores further 1s.
REQ-028 Flag, flag, flag -> three Flag_Detect pulses, no frame events.
REQ-029 N_CH=4, independent streams on all channels, with ClrCnt asserted in the same cycle as ch1 Frame_Ok -> ch1 Frame_Cnt=0 afterwards. Other channels keep their counts except those cleared.

Source files
------------

// File: rtl/hdlc_mon_pkg.sv
// rtl/hdlc_mon_pkg.sv - shared state type and line-code constants for the HDLC line monitor
package hdlc_mon_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } monState_t;

    localparam logic [7:0] FLAG_PATTERN = 8'h7E;
    localparam logic [2:0] STUFF_ONES   = 3'd5;
    localparam logic [2:0] ABORT_ONES   = 3'd7;

    // Run length of consecutive ones after sampling bitIn; sticks at 7 so a long
    // idle fill never wraps back into the stuffing/abort range.
    function automatic logic [2:0] nextOnes(input logic [2:0] ones, input logic bitIn);
        if (!bitIn) begin
            return 3'd0;
        end else if (ones == 3'd7) begin
            return 3'd7;
        end else begin
            return ones + 3'd1;
        end
    endfunction

endpackage

// File: rtl/hdlc_line_monitor_ch.sv
// rtl/hdlc_line_monitor_ch.sv - single-line HDLC flag/frame/abort monitor with statistics
module hdlc_line_monitor_ch
    import hdlc_mon_pkg::*;
#(
    parameter int MIN_BYTES = 1,
    parameter int MAX_BYTES = 128,
    parameter int CNT_W     = 8,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Line,
    input  logic             Enable,
    input  logic             ClrCnt,
    output logic             Flag_Detect,
    output logic             Abort_Detect,
    output logic             Frame_Ok,
    output logic             Frame_Err,
    output logic [LEN_W-1:0] Frame_Bytes,
    output logic [CNT_W-1:0] Frame_Cnt,
    output logic [CNT_W-1:0] Err_Cnt,
    output logic [CNT_W-1:0] Abort_Cnt
);

    // Bit counter stops two bytes past the largest legal frame, enough to tell
    // "too long" apart from any legal length without ever wrapping.
    localparam int BC_MAX = (MAX_BYTES + 2) * 8;
    localparam int BC_W   = $clog2(BC_MAX + 1);
    localparam int BYTE_W = BC_W - 2;

    monState_t       state;
    logic [7:0]      sr;
    logic [7:0]      srNext;
    logic [2:0]      onesCnt;
    logic [2:0]      onesNext;
    logic [BC_W-1:0] bitCnt;
    logic [BC_W-1:0] bitCntInc;
    logic [BC_W:0]   bitsPlus1;
    logic [BC_W:0]   contentBits;
    logic [BYTE_W-1:0] byteCnt;
    logic            flagHit;
    logic            abortHit;
    logic            stuffBit;
    logic            bcSat;
    logic            emptyFrame;
    logic            goodFrame;

    // Decode the incoming bit against the history: flag, abort, stuffed zero and frame length.
    always_comb begin
        srNext      = {sr[6:0], Line};
        onesNext    = nextOnes(onesCnt, Line);
        flagHit     = (srNext == FLAG_PATTERN);
        abortHit    = (onesNext == ABORT_ONES);
        stuffBit    = !Line && (onesCnt == STUFF_ONES);
        bcSat       = (bitCnt == BC_W'(BC_MAX));
        bitCntInc   = bcSat ? bitCnt : bitCnt + BC_W'(1);
        // The closing flag's first seven bits are already in bitCnt; adding the
        // completing bit and removing the eight flag bits leaves the content.
        bitsPlus1   = {1'b0, bitCnt} + (BC_W + 1)'(1);
        contentBits = bitsPlus1 - (BC_W + 1)'(8);
        byteCnt     = contentBits[BC_W:3];
        emptyFrame  = (bitsPlus1 == (BC_W + 1)'(8));
        goodFrame   = !bcSat
                   && (bitsPlus1 > (BC_W + 1)'(8))
                   && (contentBits[2:0] == 3'd0)
                   && (byteCnt >= BYTE_W'(MIN_BYTES))
                   && (byteCnt <= BYTE_W'(MAX_BYTES));
    end

    // Per-line frame FSM with registered one-cycle event pulses and the last good length.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            sr           <= 8'hFF;
            onesCnt      <= 3'd0;
            bitCnt       <= '0;
            Flag_Detect  <= 1'b0;
            Abort_Detect <= 1'b0;
            Frame_Ok     <= 1'b0;
            Frame_Err    <= 1'b0;
            Frame_Bytes  <= '0;
        end else begin
            Flag_Detect  <= 1'b0;
            Abort_Detect <= 1'b0;
            Frame_Ok     <= 1'b0;
            Frame_Err    <= 1'b0;
            if (!Enable) begin
                state   <= IDLE;
                sr      <= 8'hFF;
                onesCnt <= 3'd0;
                bitCnt  <= '0;
            end else begin
                sr          <= srNext;
                onesCnt     <= onesNext;
                Flag_Detect <= flagHit;
                case (state)
                    IDLE: begin
                        // Ones here are idle fill; only a flag opens a frame.
                        if (flagHit) begin
                            state  <= ACTIVE;
                            bitCnt <= '0;
                        end
                    end
                    ACTIVE: begin
                        if (flagHit) begin
                            // Closing flag also opens the next frame.
                            bitCnt <= '0;
                            if (!emptyFrame) begin
                                if (goodFrame) begin
                                    Frame_Ok    <= 1'b1;
                                    Frame_Bytes <= LEN_W'(byteCnt);
                                end else begin
                                    Frame_Err   <= 1'b1;
                                end
                            end
                        end else if (abortHit) begin
                            state        <= IDLE;
                            bitCnt       <= '0;
                            Abort_Detect <= 1'b1;
                        end else if (!stuffBit) begin
                            bitCnt <= bitCntInc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Saturating statistics driven by the registered pulses; a clear beats a coincident increment.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Frame_Cnt <= '0;
            Err_Cnt   <= '0;
            Abort_Cnt <= '0;
        end else if (ClrCnt) begin
            Frame_Cnt <= '0;
            Err_Cnt   <= '0;
            Abort_Cnt <= '0;
        end else begin
            if (Frame_Ok && !(&Frame_Cnt)) begin
                Frame_Cnt <= Frame_Cnt + CNT_W'(1);
            end
            if (Frame_Err && !(&Err_Cnt)) begin
                Err_Cnt <= Err_Cnt + CNT_W'(1);
            end
            if (Abort_Detect && !(&Abort_Cnt)) begin
                Abort_Cnt <= Abort_Cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hdlc_line_monitor.sv
// rtl/hdlc_line_monitor.sv - multi-line HDLC monitor: one channel instance per serial line
module hdlc_line_monitor
    import hdlc_mon_pkg::*;
#(
    parameter int N_CH      = 1,
    parameter int MIN_BYTES = 1,
    parameter int MAX_BYTES = 128,
    parameter int CNT_W     = 8
) (
    input  logic                                      Clk,
    input  logic                                      Rst,
    input  logic [N_CH-1:0]                           Line,
    input  logic [N_CH-1:0]                           Enable,
    input  logic                                      ClrCnt,
    output logic [N_CH-1:0]                           Flag_Detect,
    output logic [N_CH-1:0]                           Abort_Detect,
    output logic [N_CH-1:0]                           Frame_Ok,
    output logic [N_CH-1:0]                           Frame_Err,
    output logic [N_CH*$clog2(MAX_BYTES+1)-1:0]       Frame_Bytes,
    output logic [N_CH*CNT_W-1:0]                     Frame_Cnt,
    output logic [N_CH*CNT_W-1:0]                     Err_Cnt,
    output logic [N_CH*CNT_W-1:0]                     Abort_Cnt
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);

    // Lines share nothing but clock, reset and the counter clear.
    for (genvar g = 0; g < N_CH; g++) begin : gCh
        hdlc_line_monitor_ch #(
            .MIN_BYTES (MIN_BYTES),
            .MAX_BYTES (MAX_BYTES),
            .CNT_W     (CNT_W),
            .LEN_W     (LEN_W)
        ) uCh (
            .Clk          (Clk),
            .Rst          (Rst),
            .Line         (Line[g]),
            .Enable       (Enable[g]),
            .ClrCnt       (ClrCnt),
            .Flag_Detect  (Flag_Detect[g]),
            .Abort_Detect (Abort_Detect[g]),
            .Frame_Ok     (Frame_Ok[g]),
            .Frame_Err    (Frame_Err[g]),
            .Frame_Bytes  (Frame_Bytes[g*LEN_W +: LEN_W]),
            .Frame_Cnt    (Frame_Cnt[g*CNT_W +: CNT_W]),
            .Err_Cnt      (Err_Cnt[g*CNT_W +: CNT_W]),
            .Abort_Cnt    (Abort_Cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb/tb_hdlc_line_monitor.sv - randomized self-checking bench for hdlc_line_monitor
module tb_hdlc_line_monitor;

    localparam int N_CH      = 4;
    localparam int MIN_BYTES = 1;
    localparam int MAX_BYTES = 4;
    localparam int CNT_W     = 8;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                    Clk = 1'b0;
    logic                    Rst;
    logic [N_CH-1:0]         Line;
    logic [N_CH-1:0]         Enable;
    logic                    ClrCnt;
    logic [N_CH-1:0]         Flag_Detect;
    logic [N_CH-1:0]         Abort_Detect;
    logic [N_CH-1:0]         Frame_Ok;
    logic [N_CH-1:0]         Frame_Err;
    logic [N_CH*LEN_W-1:0]   Frame_Bytes;
    logic [N_CH*CNT_W-1:0]   Frame_Cnt;
    logic [N_CH*CNT_W-1:0]   Err_Cnt;
    logic [N_CH*CNT_W-1:0]   Abort_Cnt;

    hdlc_line_monitor #(
        .N_CH      (N_CH),
        .MIN_BYTES (MIN_BYTES),
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Line         (Line),
        .Enable       (Enable),
        .ClrCnt       (ClrCnt),
        .Flag_Detect  (Flag_Detect),
        .Abort_Detect (Abort_Detect),
        .Frame_Ok     (Frame_Ok),
        .Frame_Err    (Frame_Err),
        .Frame_Bytes  (Frame_Bytes),
        .Frame_Cnt    (Frame_Cnt),
        .Err_Cnt      (Err_Cnt),
        .Abort_Cnt    (Abort_Cnt)
    );

    always #5 Clk = ~Clk;

    // One line bit plus the events a spec-level transmitter model expects for it.
    typedef struct {
        bit b;
        bit en;
        bit fl;
        bit ab;
        bit ok;
        bit er;
        int nb;
    } ev_t;

    ev_t q[N_CH][$];
    bit  mActive[N_CH];
    int  mOnes[N_CH];
    int  mContent[N_CH];
    int  okIdx[N_CH];
    int  expFrame[N_CH];
    int  expErr[N_CH];
    int  expAbort[N_CH];
    int  lastBytes[N_CH];
    int  checks = 0;
    int  passed = 0;

    task automatic put(int ch, bit b, bit en, bit fl, bit ok, bit er, int nb);
        ev_t e;
        e.b = b; e.en = en; e.fl = fl; e.ok = ok; e.er = er; e.nb = nb; e.ab = 0;
        if (!en) begin
            mOnes[ch] = 0;
            mActive[ch] = 0;
        end else if (b) begin
            if (mOnes[ch] < 7) mOnes[ch]++;
            if (mActive[ch] && mOnes[ch] == 7) begin
                e.ab = 1;
                mActive[ch] = 0;
            end
        end else begin
            mOnes[ch] = 0;
        end
        if (ok) okIdx[ch] = q[ch].size();
        q[ch].push_back(e);
    endtask

    task automatic push_flag(int ch);
        bit ok = 0;
        bit er = 0;
        int nb = 0;
        if (mActive[ch] && mContent[ch] != 0) begin
            if (mContent[ch] % 8 == 0 && mContent[ch] / 8 >= MIN_BYTES && mContent[ch] / 8 <= MAX_BYTES) begin
                ok = 1;
                nb = mContent[ch] / 8;
            end else begin
                er = 1;
            end
        end
        put(ch, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) put(ch, 1, 1, 0, 0, 0, 0);
        put(ch, 0, 1, 1, ok, er, nb);
        mActive[ch] = 1;
        mContent[ch] = 0;
    endtask

    task automatic push_data(int ch, bit b);
        put(ch, b, 1, 0, 0, 0, 0);
        if (mActive[ch]) mContent[ch]++;
        if (b && mOnes[ch] == 5) put(ch, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic push_byte(int ch, logic [7:0] v);
        for (int i = 0; i < 8; i++) push_data(ch, v[i]);
    endtask

    task automatic push_idle(int ch, int k);
        for (int i = 0; i < k; i++) put(ch, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic push_off(int ch, int k);
        for (int i = 0; i < k; i++) put(ch, 1'($urandom), 0, 0, 0, 0, 0);
    endtask

    task automatic bump(inout int c);
        if (c < CNT_MAX) c++;
    endtask

    task automatic check_counters(string tag);
        for (int ch = 0; ch < N_CH; ch++) begin
            checks++;
            if (Frame_Cnt[ch*CNT_W +: CNT_W] !== CNT_W'(expFrame[ch]))
                $display("FAIL %s frame_cnt ch%0d got %0d exp %0d", tag, ch, Frame_Cnt[ch*CNT_W +: CNT_W], expFrame[ch]);
            else passed++;
            checks++;
            if (Err_Cnt[ch*CNT_W +: CNT_W] !== CNT_W'(expErr[ch]))
                $display("FAIL %s err_cnt ch%0d got %0d exp %0d", tag, ch, Err_Cnt[ch*CNT_W +: CNT_W], expErr[ch]);
            else passed++;
            checks++;
            if (Abort_Cnt[ch*CNT_W +: CNT_W] !== CNT_W'(expAbort[ch]))
                $display("FAIL %s abort_cnt ch%0d got %0d exp %0d", tag, ch, Abort_Cnt[ch*CNT_W +: CNT_W], expAbort[ch]);
            else passed++;
            checks++;
            if (Frame_Bytes[ch*LEN_W +: LEN_W] !== LEN_W'(lastBytes[ch]))
                $display("FAIL %s bytes_hold ch%0d got %0d exp %0d", tag, ch, Frame_Bytes[ch*LEN_W +: LEN_W], lastBytes[ch]);
            else passed++;
        end
    endtask

    // Pads all lines to equal length, ends with one disabled bit to park every channel in IDLE.
    task automatic run_streams(string tag, int clrAt);
        int maxLen = 0;
        for (int ch = 0; ch < N_CH; ch++) if (q[ch].size() > maxLen) maxLen = q[ch].size();
        for (int ch = 0; ch < N_CH; ch++) begin
            push_idle(ch, maxLen - q[ch].size());
            push_off(ch, 1);
        end
        for (int t = 0; t < maxLen + 1; t++) begin
            ClrCnt = (t == clrAt + 1);
            if (t == clrAt + 1) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    expFrame[ch] = 0; expErr[ch] = 0; expAbort[ch] = 0;
                end
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                Line[ch]   = q[ch][t].b;
                Enable[ch] = q[ch][t].en;
            end
            @(posedge Clk);
            #1;
            for (int ch = 0; ch < N_CH; ch++) begin
                ev_t e;
                logic [3:0] got;
                logic [3:0] exp;
                e = q[ch][t];
                got = {Flag_Detect[ch], Abort_Detect[ch], Frame_Ok[ch], Frame_Err[ch]};
                exp = {e.fl, e.ab, e.ok, e.er};
                checks++;
                if (got !== exp)
                    $display("FAIL %s pulses ch%0d bit%0d got %b exp %b (flag,abort,ok,err)", tag, ch, t, got, exp);
                else passed++;
                if (e.ok) begin
                    checks++;
                    if (Frame_Bytes[ch*LEN_W +: LEN_W] !== LEN_W'(e.nb))
                        $display("FAIL %s frame_bytes ch%0d bit%0d got %0d exp %0d", tag, ch, t, Frame_Bytes[ch*LEN_W +: LEN_W], e.nb);
                    else passed++;
                    lastBytes[ch] = e.nb;
                    bump(expFrame[ch]);
                end
                if (e.er) bump(expErr[ch]);
                if (e.ab) bump(expAbort[ch]);
            end
        end
        ClrCnt = 1'b0;
        check_counters(tag);
        Enable = '1;
        Line   = '1;
        for (int ch = 0; ch < N_CH; ch++) q[ch].delete();
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            mActive[ch] = 0; mOnes[ch] = 0; mContent[ch] = 0; okIdx[ch] = 0;
            expFrame[ch] = 0; expErr[ch] = 0; expAbort[ch] = 0; lastBytes[ch] = 0;
            q[ch].delete();
        end
    endtask

    task automatic check_all_zero(string tag);
        checks++;
        if ({Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err} !== '0)
            $display("FAIL %s pulses got %h exp 0", tag, {Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err});
        else passed++;
        checks++;
        if ({Frame_Cnt, Err_Cnt, Abort_Cnt} !== '0)
            $display("FAIL %s counters got %h exp 0", tag, {Frame_Cnt, Err_Cnt, Abort_Cnt});
        else passed++;
        checks++;
        if (Frame_Bytes !== '0)
            $display("FAIL %s frame_bytes got %h exp 0", tag, Frame_Bytes);
        else passed++;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Line = '1; Enable = '1; ClrCnt = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Rst = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(posedge Clk);
            #1;
            checks++;
            if ({Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err} !== '0)
                $display("FAIL idle_fill pulses cycle%0d got %h exp 0", t, {Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err});
            else passed++;
        end
        check_all_zero("idle_fill_end");
    endtask

    task automatic test_good_frame();
        push_flag(0);
        push_byte(0, 8'hA5);
        push_byte(0, 8'hFF);
        push_flag(0);
        run_streams("good_frame", -10);
        checks++;
        if (Frame_Cnt[0 +: CNT_W] !== CNT_W'(1) || Err_Cnt[0 +: CNT_W] !== CNT_W'(0) || Frame_Bytes[0 +: LEN_W] !== LEN_W'(2))
            $display("FAIL good_frame_stats got cnt=%0d err=%0d bytes=%0d exp 1/0/2", Frame_Cnt[0 +: CNT_W], Err_Cnt[0 +: CNT_W], Frame_Bytes[0 +: LEN_W]);
        else passed++;
    endtask

    task automatic test_bad_length();
        push_flag(0);
        for (int i = 0; i < 12; i++) push_data(0, 1'($urandom));
        push_flag(0);
        for (int i = 0; i < 5; i++) push_byte(0, 8'($urandom));
        push_flag(0);
        run_streams("bad_length", -10);
        checks++;
        if (Err_Cnt[0 +: CNT_W] !== CNT_W'(2))
            $display("FAIL bad_length_err_cnt got %0d exp 2", Err_Cnt[0 +: CNT_W]);
        else passed++;
    endtask

    task automatic test_abort();
        push_flag(0);
        push_byte(0, 8'h55);
        push_idle(0, 8);
        push_idle(0, 12);
        run_streams("abort", -10);
        checks++;
        if (Abort_Cnt[0 +: CNT_W] !== CNT_W'(1) || Frame_Cnt[0 +: CNT_W] !== CNT_W'(1))
            $display("FAIL abort_stats got abort=%0d frame=%0d exp 1/1", Abort_Cnt[0 +: CNT_W], Frame_Cnt[0 +: CNT_W]);
        else passed++;
    endtask

    task automatic test_flags();
        int nFlags;
        push_flag(0);
        push_flag(0);
        push_flag(0);
        nFlags = 0;
        foreach (q[0][i]) if (q[0][i].fl) nFlags++;
        run_streams("flags", -10);
        checks++;
        if (nFlags !== 3 || Frame_Cnt[0 +: CNT_W] !== CNT_W'(1) || Err_Cnt[0 +: CNT_W] !== CNT_W'(2))
            $display("FAIL flags_stats got flags=%0d frame=%0d err=%0d exp 3/1/2", nFlags, Frame_Cnt[0 +: CNT_W], Err_Cnt[0 +: CNT_W]);
        else passed++;
    endtask

    task automatic build_random(int ch);
        int segs = $urandom_range(2, 5);
        for (int s = 0; s < segs; s++) begin
            int k = $urandom_range(0, 4);
            case (k)
                0: begin
                    int nb = $urandom_range(1, 5);
                    if (!mActive[ch]) begin
                        push_idle(ch, $urandom_range(0, 3));
                        push_flag(ch);
                    end
                    for (int i = 0; i < nb; i++) push_byte(ch, 8'($urandom));
                    push_flag(ch);
                end
                1: begin
                    int n = $urandom_range(1, 45);
                    if (!mActive[ch]) push_flag(ch);
                    for (int i = 0; i < n; i++) push_data(ch, 1'($urandom));
                    push_flag(ch);
                end
                2: begin
                    int n = $urandom_range(0, 20);
                    if (!mActive[ch]) push_flag(ch);
                    for (int i = 0; i < n; i++) push_data(ch, 1'($urandom));
                    push_idle(ch, $urandom_range(7, 10));
                end
                3: push_off(ch, $urandom_range(1, 4));
                default: begin
                    push_flag(ch);
                    push_flag(ch);
                end
            endcase
        end
    endtask

    task automatic test_multichannel_clear();
        int clrAt;
        build_random(0);
        push_flag(1);
        push_byte(1, 8'h3C);
        push_byte(1, 8'hF7);
        push_flag(1);
        clrAt = okIdx[1];
        build_random(2);
        push_flag(3);
        push_byte(3, 8'h81);
        push_off(3, 3);
        push_flag(3);
        push_byte(3, 8'h7E);
        push_flag(3);
        for (int ch = 0; ch < N_CH; ch++) if (ch != 1) build_random(ch);
        run_streams("multichannel_clear", clrAt);
        checks++;
        if (Frame_Cnt[1*CNT_W +: CNT_W] !== CNT_W'(0))
            $display("FAIL clear_wins ch1 frame_cnt got %0d exp 0", Frame_Cnt[1*CNT_W +: CNT_W]);
        else passed++;
    endtask

    task automatic test_back_to_back_random();
        for (int r = 0; r < 6; r++) begin
            for (int ch = 0; ch < N_CH; ch++) build_random(ch);
            run_streams("random", -10);
        end
    endtask

    task automatic test_reset_midframe();
        push_flag(0);
        push_byte(0, 8'hA5);
        for (int t = 0; t < q[0].size(); t++) begin
            Line = '1;
            Line[0] = q[0][t].b;
            @(posedge Clk);
        end
        #2;
        Rst = 1'b1;
        #1;
        check_all_zero("reset_midframe");
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        Line = '1;
        model_reset();
        for (int t = 0; t < 10; t++) begin
            @(posedge Clk);
            #1;
            checks++;
            if ({Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err} !== '0)
                $display("FAIL reset_release pulses cycle%0d got %h exp 0", t, {Flag_Detect, Abort_Detect, Frame_Ok, Frame_Err});
            else passed++;
        end
        check_all_zero("reset_release_end");
        push_flag(2);
        push_byte(2, 8'hC3);
        push_flag(2);
        run_streams("after_reset", -10);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_length();
        test_abort();
        test_flags();
        test_multichannel_clear();
        test_back_to_back_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
